// File: rtl/csk_pipelined_subtractor.sv
// Pipelined a - b (as a + ~b + 1). Each stage resolves one BLOCK-bit carry-skip slice.
// Valid/ready handshake on both sides; empty stages refill even while the output is stalled.
module csk_pipelined_subtractor #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned N   = WIDTH / BLOCK;
   localparam int unsigned MSB = WIDTH - 1;

   logic [N-1:0]            v_q, v_d;
   logic [N-1:0]            c_q, c_d;
   logic [N-1:0][WIDTH-1:0] diff_q, diff_d;
   logic [N-1:0][WIDTH-1:0] a_q, a_d;
   logic [N-1:0][WIDTH-1:0] nb_q, nb_d;
   logic [N-1:0]            load;

   // A stage may load if it is empty or the stage after it is loading.
   always_comb begin
      logic ld;
      ld   = out_ready;
      load = '0;
      for (int unsigned i = 0; i < N; i++) begin
         ld            = ~v_q[N-1-i] | ld;
         load[N-1-i]   = ld;
      end
   end

   assign in_ready = load[0];

   always_comb begin
      logic             src_v;
      logic             cin;
      logic             carry;
      logic             allp;
      logic             p;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_nb;
      logic [WIDTH-1:0] src_diff;

      v_d    = v_q;
      c_d    = c_q;
      diff_d = diff_q;
      a_d    = a_q;
      nb_d   = nb_q;

      src_v    = in_valid;
      src_a    = a;
      src_nb   = ~b;
      src_diff = '0;
      cin      = 1'b1;

      // Each iteration consumes the previous stage's registers as its source, so
      // the upstream of stage 0 is simply the input port.
      for (int unsigned k = 0; k < N; k++) begin
         carry = cin;
         allp  = 1'b1;
         for (int unsigned j = 0; j < BLOCK; j++) begin
            p                       = src_a[k*BLOCK+j] ^ src_nb[k*BLOCK+j];
            src_diff[k*BLOCK+j]     = p ^ carry;
            carry                   = (src_a[k*BLOCK+j] & src_nb[k*BLOCK+j]) | (p & carry);
            allp                    = allp & p;
         end

         if (load[k]) begin
            v_d[k] = src_v;
            if (src_v) begin
               diff_d[k] = src_diff;
               c_d[k]    = allp ? cin : carry;
               a_d[k]    = src_a;
               nb_d[k]   = src_nb;
            end
         end

         src_v    = v_q[k];
         src_a    = a_q[k];
         src_nb   = nb_q[k];
         src_diff = diff_q[k];
         cin      = c_q[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q    <= '0;
         c_q    <= '0;
         diff_q <= '0;
         a_q    <= '0;
         nb_q   <= '0;
      end else begin
         v_q    <= v_d;
         c_q    <= c_d;
         diff_q <= diff_d;
         a_q    <= a_d;
         nb_q   <= nb_d;
      end
   end

   assign out_valid = v_q[N-1];
   assign diff      = diff_q[N-1];
   assign borrow    = ~c_q[N-1];
   assign zero      = ~|diff_q[N-1];
   // Sign of b is recovered from the stored ~b.
   assign ovf       = (a_q[N-1][MSB] ^ ~nb_q[N-1][MSB]) & (diff_q[N-1][MSB] ^ a_q[N-1][MSB]);

endmodule

// File: tb/tb_csk_pipelined_subtractor.sv
// Randomized bench for csk_pipelined_subtractor against an arithmetic reference model.
module tb_csk_pipelined_subtractor;

   localparam int W = 16;
   localparam int B = 4;
   localparam int N = W / B;
   localparam longint SMAX = (longint'(1) << (W-1)) - 1;
   localparam longint SMIN = -(longint'(1) << (W-1));

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;
   logic         zero;

   csk_pipelined_subtractor #(.WIDTH(W), .BLOCK(B)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      logic         z;
   } res_t;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   acc_count = 0;
   res_t exp_q[$];
   int   out_cyc[$];
   res_t e;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      res_t   r;
      longint sx, sy, s;
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      s    = sx - sy;
      r.d  = x - y;
      r.br = (x < y);
      r.ov = (s > SMAX) || (s < SMIN);
      r.z  = (r.d == '0);
      return r;
   endfunction

   // Scoreboard: ordering, results and the ready rule, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready_rule", in_ready, (out_ready || exp_q.size() < N));
         if (out_valid && out_ready) begin
            check("out_has_txn", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("diff", diff, e.d);
               check("borrow", borrow, e.br);
               check("ovf", ovf, e.ov);
               check("zero", zero, e.z);
            end
            out_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_sub(a, b));
            last_acc = cyc;
            acc_count++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
      logic got;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      tick();
      in_valid = 1'b0;
      got      = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("result_seen", got, 1);
      if (got) begin
         check("latency", cyc - last_acc, N);
         check("dir_diff", diff, ed);
         check("dir_borrow", borrow, eb);
         check("dir_ovf", ovf, eo);
         check("dir_zero", zero, ez);
      end
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   s;
      int   n0;
      res_t snap;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_zero", zero, 1);
      check("rst_borrow", borrow, 1);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      run_one(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
      run_one(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_one(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      run_one(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);

      // Back-to-back stream.
      out_cyc.delete();
      s = 0;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         a        = W'($urandom);
         b        = W'($urandom);
         tick();
         if (i == 0) s = last_acc;
      end
      in_valid = 1'b0;
      repeat (8) tick();
      check("stream_count", out_cyc.size(), 64);
      if (out_cyc.size() == 64) begin
         check("stream_first", out_cyc[0], s + N);
         check("stream_last", out_cyc[63], s + N + 63);
      end

      // Stall with the pipeline full.
      out_ready = 1'b0;
      n0        = acc_count;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         a        = W'($urandom);
         b        = W'($urandom);
         tick();
      end
      check("bp_accepts", acc_count - n0, N);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      snap = {diff, borrow, ovf, zero};
      for (int i = 0; i < 5; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         tick();
         check("bp_stable", {diff, borrow, ovf, zero}, snap);
         check("bp_hold_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      out_cyc.delete();
      repeat (6) tick();
      check("bp_drain_count", out_cyc.size(), N);
      if (out_cyc.size() == N) check("bp_drain_span", out_cyc[N-1] - out_cyc[0], N - 1);

      // Alternating input with random output stalls.
      for (int i = 0; i < 300; i++) begin
         in_valid  = (i % 2) == 0;
         a         = W'($urandom);
         b         = W'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      check("bubble_drained", exp_q.size(), 0);

      // Reset with three transactions in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = W'($urandom);
         b        = W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_diff", diff, 0);
      check("mid_rst_borrow", borrow, 1);
      check("mid_rst_zero", zero, 1);
      check("mid_rst_in_ready", in_ready, 1);
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      out_cyc.delete();
      repeat (10) tick();
      check("post_rst_no_output", out_cyc.size(), 0);

      run_one(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
